// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential divider: state encoding, default
// widths and the handshake level constants.
package div_seq_pkg;

    localparam int unsigned DIV_WIDTH = 32;  // default operand width
    localparam int unsigned DIV_CNT_W = 6;   // default iteration counter width

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'd0,
        DIV_BYZERO  = 2'd1,
        DIV_ON      = 2'd2,
        DIV_END     = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_seq_step.sv
// One restoring divide step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits and record the quotient bit.
//   rem, quot     current partial remainder / remaining dividend+quotient bits
//   divisor       magnitude of the divisor
//   rem_next      partial remainder after this step
//   quot_next     quot shifted left with the new quotient bit in the LSB
module div_seq_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quot,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quot_next
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // rem < divisor holds between steps, so the difference always fits WIDTH bits
    always_comb begin
        shifted = {rem, quot[WIDTH-1]};
        diff    = shifted[WIDTH-1:0] - divisor;
        if (shifted >= {1'b0, divisor}) begin
            rem_next  = diff;
            quot_next = {quot[WIDTH-2:0], 1'b1};
        end else begin
            rem_next  = shifted[WIDTH-1:0];
            quot_next = {quot[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU beside the execute stage.
// Operands are held by the requester with start_i until ready_o is seen; the
// result {remainder, quotient} stays valid while start_i remains high.
// Optional macro DIV_EARLY_OUT_EN: when |dividend| < |divisor| the result
// is produced immediately instead of after WIDTH iterations.
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   signed_div_i  1 = signed (DIV), 0 = unsigned (DIVU)
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       request, held until ready_o
//   annul_i       flush, aborts any division in flight
//   result_o      {remainder, quotient}, valid while ready_o
//   ready_o       result valid
//   busy_o        division in flight (stall request)
module div_seq
    import div_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned CNT_W = DIV_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o
);

    div_state_e         state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [WIDTH-1:0]   rem, rem_d, quot, quot_d, dvsr, dvsr_d;
    logic               neg_dvd, neg_dvd_d, neg_dvs, neg_dvs_d;
    logic               is_signed, is_signed_d;
    logic               ready_d;
    logic [2*WIDTH-1:0] result_d;

    logic               in_neg_dvd, in_neg_dvs, early, abort;
    logic [WIDTH-1:0]   dvd_abs, dvs_abs;
    logic [WIDTH-1:0]   step_rem, step_quot, rem_fix, quot_fix;

    // operand magnitudes; the most negative value maps onto itself, which is
    // the correct unsigned magnitude
    assign in_neg_dvd = signed_div_i & opdata1_i[WIDTH-1];
    assign in_neg_dvs = signed_div_i & opdata2_i[WIDTH-1];
    assign dvd_abs    = in_neg_dvd ? -opdata1_i : opdata1_i;
    assign dvs_abs    = in_neg_dvs ? -opdata2_i : opdata2_i;

`ifdef DIV_EARLY_OUT_EN
    assign early = (dvd_abs < dvs_abs);
`else
    assign early = 1'b0;
`endif

    assign abort  = annul_i | (start_i == DIV_STOP);
    assign busy_o = (state == DIV_BYZERO) || (state == DIV_ON);

    div_seq_step #(.WIDTH(WIDTH)) u_div_step (
        .rem       (rem),
        .quot      (quot),
        .divisor   (dvsr),
        .rem_next  (step_rem),
        .quot_next (step_quot)
    );

    // sign fix-up applied to the final step's output
    assign quot_fix = (is_signed && (neg_dvd != neg_dvs)) ? -step_quot : step_quot;
    assign rem_fix  = (is_signed && neg_dvd) ? -step_rem : step_rem;

    // state, work registers and outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= DIV_FREE;
            cnt       <= '0;
            rem       <= '0;
            quot      <= '0;
            dvsr      <= '0;
            neg_dvd   <= 1'b0;
            neg_dvs   <= 1'b0;
            is_signed <= 1'b0;
            ready_o   <= DIV_RESULT_NOT_READY;
            result_o  <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            rem       <= rem_d;
            quot      <= quot_d;
            dvsr      <= dvsr_d;
            neg_dvd   <= neg_dvd_d;
            neg_dvs   <= neg_dvs_d;
            is_signed <= is_signed_d;
            ready_o   <= ready_d;
            result_o  <= result_d;
        end
    end

    // next-state, work-register and output logic
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        rem_d       = rem;
        quot_d      = quot;
        dvsr_d      = dvsr;
        neg_dvd_d   = neg_dvd;
        neg_dvs_d   = neg_dvs;
        is_signed_d = is_signed;
        ready_d     = DIV_RESULT_NOT_READY;
        result_d    = '0;

        case (state)
            DIV_FREE: begin
                if ((start_i == DIV_START) && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = DIV_BYZERO;
                    end else if (early) begin
                        // quotient 0, remainder is the dividend unchanged
                        state_d  = DIV_END;
                        ready_d  = DIV_RESULT_READY;
                        result_d = {opdata1_i, WIDTH'(0)};
                    end else begin
                        state_d     = DIV_ON;
                        cnt_d       = '0;
                        rem_d       = '0;
                        quot_d      = dvd_abs;
                        dvsr_d      = dvs_abs;
                        neg_dvd_d   = in_neg_dvd;
                        neg_dvs_d   = in_neg_dvs;
                        is_signed_d = signed_div_i;
                    end
                end
            end
            DIV_BYZERO: begin
                if (abort) begin
                    state_d = DIV_FREE;
                end else begin
                    state_d = DIV_END;
                    ready_d = DIV_RESULT_READY;
                end
            end
            DIV_ON: begin
                if (abort) begin
                    state_d = DIV_FREE;
                end else begin
                    rem_d  = step_rem;
                    quot_d = step_quot;
                    cnt_d  = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state_d  = DIV_END;
                        ready_d  = DIV_RESULT_READY;
                        result_d = {rem_fix, quot_fix};
                    end
                end
            end
            DIV_END: begin
                if (abort) begin
                    state_d = DIV_FREE;
                end else begin
                    ready_d  = DIV_RESULT_READY;
                    result_d = result_o;
                end
            end
            default: state_d = DIV_FREE;
        endcase
    end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed vectors with hand-derived
// results, multi-cycle corner sequences (annul, async reset) and random
// operands checked against an arithmetic reference model.
module tb_div_seq;

    localparam int W = 32;
`ifdef DIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = 33;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           signed_div = 1'b0;
    logic [W-1:0]   op1 = '0;
    logic [W-1:0]   op2 = '0;
    logic           start = 1'b0;
    logic           annul = 1'b0;
    logic [2*W-1:0] result;
    logic           ready;
    logic           busy;

    int tests_run = 0;
    int failed    = 0;

    div_seq #(.WIDTH(W), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // reference: plain 64-bit arithmetic, C-style truncating division
    function automatic void model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output int lat);
        longint sa, sb, aa, ab;
        if (b == 0) begin
            q = 0; r = 0; lat = 2;
            return;
        end
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end
        q  = 32'(sa / sb);
        r  = 32'(sa % sb);
        aa = (sa < 0) ? -sa : sa;
        ab = (sb < 0) ? -sb : sb;
        lat = (aa < ab) ? EARLY_LAT : 33;
    endfunction

    // issue one division, measure latency and busy cycles, check hold and release
    task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eq,
                           input logic [31:0] er, input int lat);
        int n;
        int busy_n;
        @(negedge clk);
        signed_div = sgn; op1 = a; op2 = b; start = 1'b1;
        n = 0; busy_n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (busy) busy_n++;
        end while (!ready && n < 40);
        check({name, " latency"}, 64'(n), 64'(lat));
        check({name, " result"}, result, {er, eq});
        check({name, " busy cycles"}, 64'(busy_n), 64'(lat - 1));
        repeat (2) @(posedge clk);
        #1;
        check({name, " hold ready"}, 64'(ready), 64'd1);
        check({name, " hold result"}, result, {er, eq});
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check({name, " release"}, {31'b0, ready, 31'b0, busy}, 64'd0);
        check({name, " release result"}, result, 64'd0);
    endtask

    vec_t vecs[10];

    initial begin
        logic [31:0] ra, rb, rq, rr;
        logic        rs;
        int          rl;
        int          seen;

        vecs[0] = '{"divu 100/7",      1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33};
        vecs[1] = '{"div -7/2",        1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33};
        vecs[2] = '{"div 7/-2",        1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33};
        vecs[3] = '{"divu by zero",    1'b0, 32'h1234,       32'd0,          32'd0,          32'd0,          2};
        vecs[4] = '{"div min/-1",      1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33};
        vecs[5] = '{"divu 3/10",       1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          EARLY_LAT};
        vecs[6] = '{"divu max/1",      1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33};
        vecs[7] = '{"div -100/-7",     1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  33};
        vecs[8] = '{"div min/2",       1'b1, 32'h8000_0000,  32'd2,          32'hC000_0000,  32'd0,          33};
        vecs[9] = '{"div -3/10",       1'b1, 32'hFFFF_FFFD,  32'd10,         32'd0,          32'hFFFF_FFFD,  EARLY_LAT};

        // reset state
        #12;
        check("reset outputs", {31'b0, ready, 31'b0, busy}, 64'd0);
        check("reset result", result, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 10; i++)
            run_div(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].lat);

        // annul around iteration 10, then no result ever appears
        @(negedge clk);
        signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        @(posedge clk); #1;
        check("annul to free", {31'b0, ready, 31'b0, busy}, 64'd0);
        @(negedge clk);
        annul = 1'b0; start = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (ready || busy) seen++;
        end
        check("annul no ready", 64'(seen), 64'd0);
        run_div("divu 9/3 after annul", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

        // annul during the by-zero cycle
        @(negedge clk);
        signed_div = 1'b0; op1 = 32'h55; op2 = 32'd0; start = 1'b1;
        @(posedge clk); #1;
        check("byzero busy", 64'(busy), 64'd1);
        @(negedge clk);
        annul = 1'b1;
        @(posedge clk); #1;
        check("byzero annul", {31'b0, ready, 31'b0, busy}, 64'd0);
        @(negedge clk);
        annul = 1'b0; start = 1'b0;

        // asynchronous reset in the middle of an iteration
        @(negedge clk);
        signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        check("busy before reset", 64'(busy), 64'd1);
        rst = 1'b0;
        #1;
        check("async reset outputs", {31'b0, ready, 31'b0, busy}, 64'd0);
        check("async reset result", result, 64'd0);
        @(negedge clk);
        start = 1'b0; rst = 1'b1;
        run_div("div min/-1 after reset", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33);

        // random operands against the reference model
        for (int i = 0; i < 40; i++) begin
            int sel;
            sel = $urandom_range(0, 7);
            rs  = 1'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = $urandom;
            case (sel)
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'hFFFF_FFFF;
                3: ra = 32'($urandom_range(0, 20));
                default: ;
            endcase
            model(rs, ra, rb, rq, rr, rl);
            run_div("random", rs, ra, rb, rq, rr, rl);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
